// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - block accumulator for the (A+B)*C product stream with valid/ready result output
// Optional rounded block mean: define PRODUCT_ACCUMULATOR_AVG_EN.
module product_accumulator #(
    parameter int LATENCY   = 3,
    parameter int N_SAMPLES = 8,
    parameter int Y_W       = 17,
    parameter int ACC_W     = Y_W + $clog2(N_SAMPLES)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [Y_W-1:0]                y_in,
    input  logic                          clear,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ACC_W-1:0]              acc_out,
    output logic [Y_W-1:0]                avg_out,
    output logic [$clog2(N_SAMPLES)-1:0]  sample_cnt,
    output logic                          overrun
);
    localparam int CNT_W = $clog2(N_SAMPLES);

    typedef enum logic {S_EMPTY, S_PENDING} state_t;

    logic [LATENCY-1:0] r_vdly;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic [ACC_W-1:0]   r_acc_out;
    logic               r_overrun;
    state_t             r_state;

    logic               w_v_al;
    logic               w_take;
    logic               w_last;
    logic               w_complete;
    logic [ACC_W-1:0]   w_sum;
    state_t             w_state_next;
    logic               w_load;
    logic               w_set_ovr;

    assign w_v_al     = r_vdly[LATENCY-1];
    assign w_take     = w_v_al && !clear;
    assign w_last     = (r_cnt == CNT_W'(N_SAMPLES - 1));
    assign w_complete = w_take && w_last;
    assign w_sum      = r_acc + ACC_W'(y_in);

    // Issue flag travels alongside the arithmetic pipeline; clear flushes in-flight products.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_vdly <= '0;
        end else begin
            r_vdly <= (r_vdly << 1) | LATENCY'(in_valid);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_take) begin
            if (w_last) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else begin
                r_acc <= w_sum;
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_set_ovr    = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_complete) begin
                    w_load       = 1'b1;
                    w_state_next = S_PENDING;
                end
            end
            S_PENDING: begin
                if (out_ready) begin
                    if (w_complete) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_next = S_EMPTY;
                    end
                end else if (w_complete) begin
                    w_set_ovr = 1'b1;
                end
            end
            default: w_state_next = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_EMPTY;
            r_acc_out <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_load) begin
                r_acc_out <= w_sum;
            end
            if (w_set_ovr) begin
                r_overrun <= 1'b1;
            end
        end
    end

`ifdef PRODUCT_ACCUMULATOR_AVG_EN
    logic [ACC_W:0]   w_round;
    logic [ACC_W:0]   w_avg_wide;
    logic [Y_W-1:0]   w_avg;
    logic [Y_W-1:0]   r_avg;

    // Round half up, then clamp to the product width.
    assign w_round    = {1'b0, w_sum} + (ACC_W+1)'(N_SAMPLES / 2);
    assign w_avg_wide = w_round >> CNT_W;
    assign w_avg      = (|w_avg_wide[ACC_W:Y_W]) ? '1 : w_avg_wide[Y_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_avg <= '0;
        end else if (w_load) begin
            r_avg <= w_avg;
        end
    end

    assign avg_out = r_avg;
`else
    assign avg_out = '0;
`endif

    assign out_valid  = (r_state == S_PENDING);
    assign acc_out    = r_acc_out;
    assign sample_cnt = r_cnt;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_product_accumulator.sv
// tb/tb_product_accumulator.sv - directed and random checks of product_accumulator against a cycle-indexed block model
module tb_product_accumulator;
    localparam int LATENCY   = 3;
    localparam int N_SAMPLES = 8;
    localparam int Y_W       = 17;
    localparam int ACC_W     = 20;
    localparam int MAXC      = 4096;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic [Y_W-1:0]    y_in = '0;
    logic              clear = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [ACC_W-1:0]  acc_out;
    logic [Y_W-1:0]    avg_out;
    logic [2:0]        sample_cnt;
    logic              overrun;

    int checks = 0;
    int failures = 0;

    // Reference state: which cycles issued operands, the products gathered so far, and the result slot.
    int      cyc = 0;
    bit      issued [0:MAXC-1];
    int      last_kill = -1;
    int      m_cnt = 0;
    longint  m_sum = 0;
    bit      m_pending = 0;
    longint  m_acc = 0;
    longint  m_avg = 0;
    bit      m_overrun = 0;

    product_accumulator #(
        .LATENCY(LATENCY), .N_SAMPLES(N_SAMPLES), .Y_W(Y_W), .ACC_W(ACC_W)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .y_in(y_in), .clear(clear),
        .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out),
        .avg_out(avg_out), .sample_cnt(sample_cnt), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint mean_of(input longint s);
`ifdef PRODUCT_ACCUMULATOR_AVG_EN
        longint a;
        a = (s + N_SAMPLES / 2) / N_SAMPLES;
        return (a > (2**Y_W - 1)) ? (2**Y_W - 1) : a;
`else
        return 0;
`endif
    endfunction

    task automatic model_edge();
        bit     v;
        bit     comp;
        longint csum;
        comp = 0;
        csum = 0;
        if (rst || clear) last_kill = cyc;
        issued[cyc] = in_valid;
        v = (cyc >= LATENCY) && issued[cyc-LATENCY] && (last_kill < cyc - LATENCY);
        if (rst) begin
            m_cnt = 0; m_sum = 0; m_pending = 0; m_acc = 0; m_avg = 0; m_overrun = 0;
        end else begin
            if (clear) begin
                m_cnt = 0; m_sum = 0;
            end else if (v) begin
                m_sum += y_in;
                m_cnt++;
                if (m_cnt == N_SAMPLES) begin
                    comp = 1; csum = m_sum; m_cnt = 0; m_sum = 0;
                end
            end
            if (comp) begin
                if (!m_pending || out_ready) begin
                    m_acc = csum; m_avg = mean_of(csum); m_pending = 1;
                end else begin
                    m_overrun = 1;
                end
            end else if (m_pending && out_ready) begin
                m_pending = 0;
            end
        end
        cyc++;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("out_valid", 32'(out_valid), 32'(m_pending));
        check("acc_out", 32'(acc_out), 32'(m_acc));
        check("avg_out", 32'(avg_out), 32'(m_avg));
        check("sample_cnt", 32'(sample_cnt), 32'(m_cnt));
        check("overrun", 32'(overrun), 32'(m_overrun));
    endtask

    task automatic run_block(input int y, input int n_issue, input int n_cycles);
        y_in = Y_W'(y);
        for (int i = 0; i < n_cycles; i++) begin
            in_valid = (i < n_issue);
            step();
        end
        in_valid = 0;
    endtask

    initial begin
        rst = 1;
        step();
        step();
        rst = 0;

        // Nominal block: (3+5)*2 = 16, eight issues.
        out_ready = 0;
        run_block((3 + 5) * 2, 8, 12);
        check("nominal_sum", 32'(acc_out), 32'd128);
`ifdef PRODUCT_ACCUMULATOR_AVG_EN
        check("nominal_avg", 32'(avg_out), 32'd16);
`endif
        out_ready = 1;
        step();
        check("nominal_drained", 32'(out_valid), 32'd0);

        // Max operands: (255+255)*255 = 130050.
        run_block((255 + 255) * 255, 8, 12);
        check("max_sum", 32'(acc_out), 32'd1040400);
`ifdef PRODUCT_ACCUMULATOR_AVG_EN
        check("max_avg", 32'(avg_out), 32'd130050);
`endif

        // Stall across two blocks: second result dropped, overrun sticky.
        out_ready = 0;
        run_block(1, 8, 13);
        run_block(2, 8, 13);
        check("stall_hold", 32'(acc_out), 32'd8);
        check("stall_overrun", 32'(overrun), 32'd1);
        out_ready = 1;
        step();
        step();
        check("stall_drained", 32'(out_valid), 32'd0);
        check("stall_sticky", 32'(overrun), 32'd1);

        // Transfer and completion in the same cycle.
        rst = 1;
        step();
        rst = 0;
        for (int i = 0; i < 20; i++) begin
            in_valid  = (i < 16);
            out_ready = (i == 18);
            y_in      = (i <= 10) ? Y_W'(5) : Y_W'(7);
            step();
            if (i == 17) check("overlap_old", 32'(acc_out), 32'd40);
            if (i == 18) begin
                check("overlap_new", 32'(acc_out), 32'd56);
                check("overlap_valid", 32'(out_valid), 32'd1);
                check("overlap_no_ovr", 32'(overrun), 32'd0);
            end
        end
        out_ready = 1;
        in_valid = 0;
        step();

        // Clear at sample_cnt=5 with products still in flight.
        y_in = 9;
        for (int i = 0; i < 12; i++) begin
            in_valid = (i < 8);
            clear    = (i == 8);
            step();
            if (i == 7) check("clear_cnt5", 32'(sample_cnt), 32'd5);
            if (i == 8) check("clear_cnt0", 32'(sample_cnt), 32'd0);
        end
        clear = 0;
        check("clear_inflight", 32'(sample_cnt), 32'd0);
        run_block(4, 8, 12);
        check("clear_next_block", 32'(acc_out), 32'd32);

        // Reset while PENDING with a partial block of three.
        out_ready = 0;
        run_block(2, 11, 14);
        check("rst_pre_cnt", 32'(sample_cnt), 32'd3);
        check("rst_pre_valid", 32'(out_valid), 32'd1);
        rst = 1;
        step();
        rst = 0;
        check("rst_acc", 32'(acc_out), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_cnt", 32'(sample_cnt), 32'd0);
        run_block(6, 8, 14);
        check("rst_next_block", 32'(acc_out), 32'd48);

        // Randomized traffic checked every cycle against the model.
        for (int i = 0; i < 1500; i++) begin
            in_valid  = ($urandom_range(0, 99) < 75);
            y_in      = Y_W'($urandom_range(0, 2**Y_W - 1));
            out_ready = ($urandom_range(0, 99) < 70);
            clear     = ($urandom_range(0, 99) < 2);
            rst       = ($urandom_range(0, 999) < 3);
            step();
        end
        rst = 0;
        clear = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/product_accumulator.md
# product_accumulator

Downstream consumer of the `(A+B)*C` arithmetic stage. It takes the stage's 17-bit product stream `Y` and re-aligns a per-issue valid flag to the stage's pipeline latency. It accumulates blocks of `N_SAMPLES` products and hands each block sum to the next stage over a valid/ready handshake, with sticky overrun detection when the consumer stalls.

## Interface
- `LATENCY`, 3: clock cycles from operand issue (A/B/C presented with `in_valid`) to the matching `Y`; must be ≥1.
- `N_SAMPLES`, 8: products per block; power of two, ≥2.
- `Y_W`, 17: product width.
- `ACC_W`, `Y_W + log2(N_SAMPLES)` (20): accumulator/result width; overflow is impossible by construction.
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: high in the cycle operands are issued to the arithmetic stage.
- `y_in` in `Y_W`: product from the arithmetic stage.
- `clear` in 1: discard the partial block.
- `out_valid` out 1: block result available.
- `out_ready` in 1: consumer accepts result.
- `acc_out` out `ACC_W`: block sum.
- `avg_out` out `Y_W`: block mean (see Configuration).
- `sample_cnt` out `log2(N_SAMPLES)`: products accumulated in the current partial block.
- `overrun` out 1: sticky, a completed block was dropped.

## Operation
- The arithmetic stage's `ce` is tied high whenever this block is in use. The valid delay line is `LATENCY` flops deep and shifts every cycle. Its output `v_al` qualifies `y_in`.
- Accumulate path, on `v_al`:
  - `cnt < N_SAMPLES-1`: `acc <= acc + y_in`, `cnt <= cnt+1`.
  - `cnt == N_SAMPLES-1`: block complete. Completion value is `acc + y_in`. `acc` and `cnt` return to 0 and the next block starts on the next `v_al`.
- Output register FSM, two states:
  - EMPTY: on completion, load `acc_out`, go to PENDING.
  - PENDING: `out_valid`=1, `acc_out` stable.
    - Transfer occurs when `out_ready`=1.
    - Transfer with no same-cycle completion: go to EMPTY.
    - Transfer and completion in the same cycle: load new value, stay PENDING.
    - Completion without transfer: new value dropped, `acc_out` kept, `overrun` <= 1.
- Accumulation never stalls. Upstream has no backpressure.
- `clear`:
  - Zeroes `acc`, `cnt` and the valid delay line, so in-flight products are discarded.
  - Does not touch the output register or `overrun`.
  - If `clear` and `v_al` occur in the same cycle, `clear` wins and the product is discarded with no completion.
- `rst`: all state to 0, FSM to EMPTY. Applies mid-block and mid-handshake alike.
- `overrun` clears only on `rst`.

## Timing
- Reset values: `out_valid`=0, `acc_out`=0, `avg_out`=0, `sample_cnt`=0, `overrun`=0.
- Operand issue at cycle t, with `in_valid` at t: `y_in` is sampled at t+`LATENCY`.
- Last product of a block sampled at cycle k: `out_valid`=1 and `acc_out` valid at k+1.
- Back-to-back blocks:
  - Issuing on every cycle yields one result every `N_SAMPLES` cycles.
  - With `out_ready` tied high, this gives no overrun and no bubble.
- A result is transferred in exactly one cycle per handshake. It is never duplicated.

## Configuration
- `PRODUCT_ACCUMULATOR_AVG_EN` defined:
  - `avg_out` is registered alongside `acc_out`.
  - Value is `(completion value + N_SAMPLES/2) >> log2(N_SAMPLES)`, i.e. round-half-up, saturated to `Y_W` bits.
  - It follows the same load/hold rules as `acc_out`.
- Not defined: `avg_out` is constant 0 and no divider/rounding logic is synthesized.

## Test plan
- Nominal block: 8 issues with A=3, B=5, C=2, giving `y_in`=16. Then `acc_out`=128 one cycle after the 8th product, and `avg_out`=16 with AVG_EN.
- Max values: A=B=C=255, `y_in`=130050, 8 samples. Then `acc_out`=1040400, no wrap, `avg_out`=130050.
- Stall/overrun:
  - Setup: `out_ready`=0 across two full blocks with `y_in`=1 then `y_in`=2.
  - Result: `acc_out` stays 8, `overrun` rises the cycle after the 2nd block completes.
  - After `out_ready`=1: a single transfer of 8 occurs, `out_valid` falls, and `overrun` stays 1 until `rst`.
- Transfer + completion in the same cycle: `out_valid` stays 1, `acc_out` changes from the old to the new sum, and `overrun`=0.
- `clear` at `sample_cnt`=5, with a product in flight: `sample_cnt`=0 next cycle, the in-flight product is ignored, and the next block of 8×`y_in`=4 gives 32.
- `rst` asserted with PENDING and `sample_cnt`=3: all outputs 0 on the next cycle, and the following block accumulates from zero.
